apb4_ps2_ctrl: RTL

APB4-attached PS/2 host controller, the next generation of our receive-only PS/2 mouse block. Supports bidirectional keyboard/mouse traffic: frame-checked receive into a parametrised FIFO, plus a host-to-device transmit engine for commands such as reset (0xFF) or enable reporting (0xF4). Error status, maskable level interrupt and a register map replace the old fixed behaviour. Sits on the peripheral APB4 bus next to the other oscc-ip slaves; pads are open-drain through the *_o / *_oen_o pairs.

---
 rtl/apb4_ps2_ctrl_if.sv | 25 ++
 rtl/apb4_ps2_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb4_ps2_ctrl_if.sv
// APB4 bus bundle shared by the oscc-ip peripheral slaves.
// APB access: psel & penable marks the access phase; the slave has pready tied high, so every access completes in that cycle.
interface apb4_if (
  input logic hclk,
  input logic hresetn
);
  logic [31:0] paddr;
  logic        pwrite;
  logic        psel;
  logic        penable;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport slave (
    input  hclk, hresetn, paddr, pwrite, psel, penable, pwdata,
    output prdata, pready, pslverr
  );

  modport master (
    input  hclk, hresetn, prdata, pready, pslverr,
    output paddr, pwrite, psel, penable, pwdata
  );
endinterface

// File: rtl/apb4_ps2_ctrl.sv
// APB4 PS/2 host controller: frame-checked RX into a FIFO, host-to-device TX engine, maskable irq.
// Optional macro APB4_PS2_TIMEOUT_EN adds an abort for stalled partial frames.
module apb4_ps2_ctrl #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned INHIBIT_CYC = 10000,
  parameter int unsigned TIMEOUT_CYC = 20000
) (
  apb4_if.slave apb4,
  input  logic  ps2_clk_i,
  output logic  ps2_clk_o,
  output logic  ps2_clk_oen_o,
  input  logic  ps2_dat_i,
  output logic  ps2_dat_o,
  output logic  ps2_dat_oen_o,
  output logic  irq_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned IW = $clog2(INHIBIT_CYC + 1);

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 64 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      INHIBIT_CYC < 1 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("apb4_ps2_ctrl: illegal parameter value");
  end

  typedef enum logic [2:0] {
    TX_IDLE    = 3'd0,
    TX_INHIBIT = 3'd1,
    TX_REQ     = 3'd2,
    TX_SHIFT   = 3'd3,
    TX_ACK     = 3'd4
  } tx_state_e;

  logic clk, rst_n;
  assign clk   = apb4.hclk;
  assign rst_n = apb4.hresetn;

  // Pad synchronisers idle high so reset release never looks like a falling edge.
  logic clk_s1_q, clk_s2_q, clk_prev_q, dat_s1_q, dat_s2_q;
  logic fall;

  logic [3:0]    ctrl_q, ctrl_d;
  logic          txdone_q, txdone_d, nack_q, nack_d, ovf_q, ovf_d;
  logic          ferr_q, ferr_d, perr_q, perr_d;
  logic          irq_q, irq_d;

  logic [3:0]    rx_bit_q, rx_bit_d;
  logic [9:0]    rx_bits_q, rx_bits_d;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;

  tx_state_e     tx_state_q, tx_state_d;
  logic [IW-1:0] inh_cnt_q, inh_cnt_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic [8:0]    tx_sh_q, tx_sh_d;

  logic acc, wr_ctrl, wr_stat, wr_wdata, rd_rdata;
  logic en, tx_busy, tx_start, rx_active, ack_fall;
  logic full, rxne, push, pop;
  logic frame_end, start_ok, stop_ok, par_ok, good;
  logic [10:0] frame;
  logic rx_to, tx_to;
  logic unused_apb;

  assign unused_apb = ^{apb4.paddr[31:5], apb4.paddr[1:0], apb4.pwdata[31:8]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk_i;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2_dat_i;
      dat_s2_q   <= dat_s1_q;
    end
  end

  assign fall = clk_prev_q & ~clk_s2_q;

  assign acc      = apb4.psel & apb4.penable;
  assign wr_ctrl  = acc & apb4.pwrite & (apb4.paddr[4:2] == 3'd0);
  assign wr_stat  = acc & apb4.pwrite & (apb4.paddr[4:2] == 3'd1);
  assign wr_wdata = acc & apb4.pwrite & (apb4.paddr[4:2] == 3'd3);
  assign rd_rdata = acc & ~apb4.pwrite & (apb4.paddr[4:2] == 3'd2);

  assign en        = ctrl_q[0];
  assign tx_busy   = (tx_state_q != TX_IDLE);
  assign tx_start  = wr_wdata & en & ~tx_busy;
  assign rx_active = en & ~tx_busy;
  assign ack_fall  = en & fall & (tx_state_q == TX_ACK);

  assign full = (cnt_q == (AW + 1)'(FIFO_DEPTH));
  assign rxne = (cnt_q != '0);

  // The eleventh bit is checked straight from the synchroniser, never stored.
  assign frame     = {dat_s2_q, rx_bits_q};
  assign frame_end = rx_active & fall & (rx_bit_q == 4'd10);
  assign start_ok  = ~frame[0];
  assign stop_ok   = frame[10];
  assign par_ok    = ^frame[9:1];
  assign good      = start_ok & stop_ok & par_ok;
  assign push      = frame_end & good & ~full;
  assign pop       = rd_rdata & rxne;

`ifdef APB4_PS2_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic rx_part, tx_part, to_fire;

  assign rx_part = rx_active & (rx_bit_q != 4'd0);
  assign tx_part = en & ((tx_state_q == TX_REQ) | (tx_state_q == TX_SHIFT) |
                         (tx_state_q == TX_ACK));
  assign to_fire = (rx_part | tx_part) & ~fall & (to_cnt_q == TW'(TIMEOUT_CYC - 1));
  assign rx_to   = to_fire & rx_part;
  assign tx_to   = to_fire & tx_part;

  always_comb begin
    to_cnt_d = to_cnt_q + 1'b1;
    if (!(rx_part | tx_part) || fall || to_fire) to_cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) to_cnt_q <= '0;
    else        to_cnt_q <= to_cnt_d;
  end
`else
  assign rx_to = 1'b0;
  assign tx_to = 1'b0;
`endif

  // TX state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_state_q <= TX_IDLE;
    else        tx_state_q <= tx_state_d;
  end

  // TX next state
  always_comb begin
    tx_state_d = tx_state_q;
    if (!en || tx_to) begin
      tx_state_d = TX_IDLE;
    end else begin
      case (tx_state_q)
        TX_IDLE:    if (tx_start) tx_state_d = TX_INHIBIT;
        TX_INHIBIT: if (inh_cnt_q == IW'(INHIBIT_CYC - 1)) tx_state_d = TX_REQ;
        TX_REQ:     if (fall) tx_state_d = TX_SHIFT;
        TX_SHIFT:   if (fall && tx_bit_q == 4'd8) tx_state_d = TX_ACK;
        TX_ACK:     if (fall) tx_state_d = TX_IDLE;
        default:    tx_state_d = TX_IDLE;
      endcase
    end
  end

  // TX pad outputs: REQ drives the start bit, SHIFT drives d0..d7 then parity.
  always_comb begin
    ps2_clk_o     = 1'b0;
    ps2_clk_oen_o = (tx_state_q != TX_INHIBIT);
    ps2_dat_oen_o = ~((tx_state_q == TX_REQ) | (tx_state_q == TX_SHIFT));
    ps2_dat_o     = 1'b1;
    if (tx_state_q == TX_REQ)   ps2_dat_o = 1'b0;
    if (tx_state_q == TX_SHIFT) ps2_dat_o = tx_sh_q[tx_bit_q];
  end

  always_comb begin
    inh_cnt_d = (tx_state_q == TX_INHIBIT) ? inh_cnt_q + 1'b1 : '0;
    tx_bit_d  = tx_bit_q;
    if (tx_state_q == TX_REQ) tx_bit_d = 4'd0;
    else if (tx_state_q == TX_SHIFT && fall) tx_bit_d = tx_bit_q + 4'd1;
    tx_sh_d = tx_sh_q;
    if (tx_start) tx_sh_d = {~^apb4.pwdata[7:0], apb4.pwdata[7:0]};
  end

  always_comb begin
    rx_bits_d = rx_bits_q;
    rx_bit_d  = rx_bit_q;
    if (rx_active && fall) begin
      if (rx_bit_q == 4'd10) rx_bit_d = 4'd0;
      else begin
        rx_bits_d[rx_bit_q] = dat_s2_q;
        rx_bit_d            = rx_bit_q + 4'd1;
      end
    end
    if (!en || tx_start || rx_to) rx_bit_d = 4'd0;
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = frame[8:1];
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    cnt_d = cnt_q + (AW + 1)'(push) - (AW + 1)'(pop);
  end

  // Status flags: a hardware set in the same cycle as a w1c clear wins.
  always_comb begin
    ctrl_d   = wr_ctrl ? apb4.pwdata[3:0] : ctrl_q;
    txdone_d = (txdone_q & ~(wr_stat & apb4.pwdata[7])) | ack_fall | tx_to;
    nack_d   = (nack_q & ~(wr_stat & apb4.pwdata[6])) | (ack_fall & dat_s2_q) | tx_to;
    ovf_d    = (ovf_q & ~(wr_stat & apb4.pwdata[4])) | (frame_end & good & full);
    ferr_d   = (ferr_q & ~(wr_stat & apb4.pwdata[3])) |
               (frame_end & ~(start_ok & stop_ok)) | rx_to;
    perr_d   = (perr_q & ~(wr_stat & apb4.pwdata[2])) | (frame_end & ~par_ok);
    irq_d    = (ctrl_q[1] & rxne) |
               (ctrl_q[2] & (perr_q | ferr_q | ovf_q | nack_q)) |
               (ctrl_q[3] & txdone_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q    <= '0;
      txdone_q  <= 1'b0;
      nack_q    <= 1'b0;
      ovf_q     <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
      irq_q     <= 1'b0;
      rx_bit_q  <= '0;
      rx_bits_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      inh_cnt_q <= '0;
      tx_bit_q  <= '0;
      tx_sh_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      txdone_q  <= txdone_d;
      nack_q    <= nack_d;
      ovf_q     <= ovf_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
      irq_q     <= irq_d;
      rx_bit_q  <= rx_bit_d;
      rx_bits_q <= rx_bits_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      inh_cnt_q <= inh_cnt_d;
      tx_bit_q  <= tx_bit_d;
      tx_sh_q   <= tx_sh_d;
      mem_q     <= mem_d;
    end
  end

  assign irq_o        = irq_q;
  assign apb4.pready  = 1'b1;
  assign apb4.pslverr = 1'b0;

  always_comb begin
    apb4.prdata = '0;
    case (apb4.paddr[4:2])
      3'd0: apb4.prdata = {28'd0, ctrl_q};
      3'd1: apb4.prdata = {16'd0, 8'(cnt_q), txdone_q, nack_q, tx_busy, ovf_q,
                           ferr_q, perr_q, full, rxne};
      3'd2: apb4.prdata = rxne ? {24'd0, mem_q[rd_ptr_q]} : 32'd0;
      default: apb4.prdata = '0;
    endcase
  end

endmodule
